// File: rtl/huffman_bit_buffer_if.sv
// Handshake and status bundle for huffman_bit_buffer: chunk load, peek window,
// consume request, flush and buffer status.
interface huffman_bit_buffer_if #(
  parameter int IN_W   = 4,
  parameter int LEN_W  = 3,
  parameter int WIN_W  = 9,
  parameter int CNT_W  = 5,
  parameter int CLEN_W = 4
);
  logic [IN_W-1:0]   in_bits;
  logic [LEN_W-1:0]  in_len;
  logic              in_valid;
  logic              in_ready;
  logic [WIN_W-1:0]  win_data;
  logic [CNT_W-1:0]  win_bits;
  logic              cons_valid;
  logic [CLEN_W-1:0] cons_len;
  logic              cons_ready;
  logic              flush;
  logic [CNT_W-1:0]  bit_count;
  logic              empty;
  logic              err;

  modport master (
    output in_bits, in_len, in_valid, cons_valid, cons_len, flush,
    input  in_ready, win_data, win_bits, cons_ready, bit_count, empty, err
  );

  modport slave (
    input  in_bits, in_len, in_valid, cons_valid, cons_len, flush,
    output in_ready, win_data, win_bits, cons_ready, bit_count, empty, err
  );
endinterface

// File: rtl/huffman_bit_buffer.sv
// MSB-first bit accumulator with variable-length load and consume in one cycle.
// Define BITBUF_ERR_EN to build the sticky protocol-error flag.
module huffman_bit_buffer #(
  parameter int IN_W   = 4,
  parameter int LEN_W  = 3,
  parameter int BUF_W  = 16,
  parameter int WIN_W  = 9,
  parameter int CNT_W  = 5,
  parameter int CLEN_W = 4
) (
  input logic                clk,
  input logic                reset,
  huffman_bit_buffer_if.slave bus
);
  localparam int XW = CNT_W + 1;
  localparam logic [XW-1:0]    BUF_X = XW'(BUF_W);
  localparam logic [XW-1:0]    IN_X  = XW'(IN_W);
  localparam logic [XW-1:0]    WIN_X = XW'(WIN_W);
  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN_W);

  logic [BUF_W-1:0] buf_r;
  logic [CNT_W-1:0] cnt_r;

  logic [XW-1:0]    cnt_x_s, len_x_s, clen_x_s, l_s, c_s, rem_s, shamt_s, next_cnt_s;
  logic             in_ready_s, cons_ready_s, load_fire_s, cons_fire_s, len_ok_s;
  logic [IN_W-1:0]  mask_s, chunk_s;
  logic [BUF_W-1:0] next_buf_s;

  // Next-state datapath: shift out the consumed head, then append the chunk behind the remainder.
  always_comb begin
    cnt_x_s      = XW'(cnt_r);
    len_x_s      = XW'(bus.in_len);
    clen_x_s     = XW'(bus.cons_len);
    in_ready_s   = (BUF_X - cnt_x_s) >= IN_X;
    cons_ready_s = (clen_x_s <= cnt_x_s) && (clen_x_s <= WIN_X);
    load_fire_s  = bus.in_valid && in_ready_s;
    cons_fire_s  = bus.cons_valid && cons_ready_s;
    len_ok_s     = len_x_s <= IN_X;
    l_s          = (load_fire_s && len_ok_s) ? len_x_s : {XW{1'b0}};
    c_s          = cons_fire_s ? clen_x_s : {XW{1'b0}};
    mask_s       = {IN_W{1'b1}} >> (IN_X - len_x_s);
    chunk_s      = (l_s != {XW{1'b0}}) ? (bus.in_bits & mask_s) : {IN_W{1'b0}};
    rem_s        = cnt_x_s - c_s;
    shamt_s      = BUF_X - rem_s - l_s;
    next_buf_s   = (buf_r << c_s) | ({{(BUF_W-IN_W){1'b0}}, chunk_s} << shamt_s);
    next_cnt_s   = rem_s + l_s;
  end

  // Buffer and bit count; flush wins over any same-cycle load or consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_r <= {BUF_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      buf_r <= {BUF_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      buf_r <= next_buf_s;
      cnt_r <= CNT_W'(next_cnt_s);
    end
  end

`ifdef BITBUF_ERR_EN
  logic err_r;
  logic err_set_s;

  // Oversized consume requests and oversized accepted chunks are protocol errors.
  always_comb begin
    err_set_s = (bus.cons_valid && ((clen_x_s > cnt_x_s) || (clen_x_s > WIN_X)))
              || (load_fire_s && !len_ok_s);
  end

  // Sticky error flag, cleared only by flush or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (bus.flush) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready   = in_ready_s;
  assign bus.cons_ready = cons_ready_s;
  assign bus.win_data   = buf_r[BUF_W-1 -: WIN_W];
  assign bus.win_bits   = (cnt_r > WIN_C) ? WIN_C : cnt_r;
  assign bus.bit_count  = cnt_r;
  assign bus.empty      = (cnt_r == {CNT_W{1'b0}});
endmodule

// File: tb/tb_huffman_bit_buffer.sv
// Directed bench for huffman_bit_buffer (default parameters, either BITBUF_ERR_EN setting).
module tb_huffman_bit_buffer;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

`ifdef BITBUF_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  huffman_bit_buffer_if bus ();
  huffman_bit_buffer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] ib, input logic [2:0] il,
                       input logic cv, input logic [3:0] cl, input logic fl);
    bus.in_valid = iv; bus.in_bits = ib; bus.in_len = il;
    bus.cons_valid = cv; bus.cons_len = cl; bus.flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 3'd0, 1'b0, 4'd1, 1'b0);
  endtask

  // Advance one clock and verify that window bits past the valid region are zero.
  task automatic tick();
    logic [8:0] ones;
    @(posedge clk);
    #1;
    ones = 9'h1FF;
    chk("zero_fill", 32'(bus.win_data & (ones >> bus.win_bits)), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #12;
    chk("rst_count", 32'(bus.bit_count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_win", 32'(bus.win_data), 32'd0);
    chk("rst_winbits", 32'(bus.win_bits), 32'd0);
    chk("rst_cons_ready", 32'(bus.cons_ready), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b1;

    // Two chunks: 011 then 0110.
    drive(1'b1, 4'b1011, 3'd3, 1'b0, 4'd1, 1'b0); tick();
    drive(1'b1, 4'b0110, 3'd4, 1'b0, 4'd1, 1'b0); tick();
    idle(); #1;
    chk("load_win", 32'(bus.win_data), 32'(9'b011011000));
    chk("load_count", 32'(bus.bit_count), 32'd7);
    chk("load_winbits", 32'(bus.win_bits), 32'd7);
    chk("load_empty", 32'(bus.empty), 32'd0);

    // Same-cycle consume 2 and load 1111.
    drive(1'b1, 4'b1111, 3'd4, 1'b1, 4'd2, 1'b0); tick();
    idle(); #1;
    chk("both_count", 32'(bus.bit_count), 32'd9);
    chk("both_win", 32'(bus.win_data), 32'(9'b101101111));
    chk("both_winbits", 32'(bus.win_bits), 32'd9);

    // Fill to 13 bits: in_ready must drop even with a consume pending.
    drive(1'b1, 4'b1010, 3'd4, 1'b0, 4'd1, 1'b0); tick();
    idle(); #1;
    chk("full_count", 32'(bus.bit_count), 32'd13);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 4'b0101, 3'd4, 1'b1, 4'd1, 1'b0); #1;
    chk("full_in_ready_cons", 32'(bus.in_ready), 32'd0);
    tick();
    idle(); #1;
    chk("full_after_count", 32'(bus.bit_count), 32'd12);
    chk("full_after_ready", 32'(bus.in_ready), 32'd1);
    chk("full_after_win", 32'(bus.win_data), 32'(9'b011011111));

    // Drain to two bits, then an illegal consume of three.
    drive(1'b0, 4'd0, 3'd0, 1'b1, 4'd10, 1'b0); #1;
    chk("cons_too_wide", 32'(bus.cons_ready), 32'd0);
    drive(1'b0, 4'd0, 3'd0, 1'b1, 4'd9, 1'b0); #1;
    chk("cons9_ready", 32'(bus.cons_ready), 32'd1);
    tick();
    drive(1'b0, 4'd0, 3'd0, 1'b1, 4'd1, 1'b0); tick();
    idle(); #1;
    chk("drain_count", 32'(bus.bit_count), 32'd2);
    chk("drain_err", 32'(bus.err), 32'd0);
    drive(1'b0, 4'd0, 3'd0, 1'b1, 4'd3, 1'b0); #1;
    chk("illegal_ready", 32'(bus.cons_ready), 32'd0);
    tick();
    idle(); #1;
    chk("illegal_count", 32'(bus.bit_count), 32'd2);
    chk("illegal_win", 32'(bus.win_data), 32'(9'b100000000));
    chk("illegal_err", 32'(bus.err), 32'(EXP_ERR));

    // Build 8 bits, then flush with a load and a consume in flight.
    drive(1'b1, 4'b1100, 3'd4, 1'b0, 4'd1, 1'b0); tick();
    drive(1'b1, 4'b0111, 3'd2, 1'b0, 4'd1, 1'b0); tick();
    idle(); #1;
    chk("preflush_count", 32'(bus.bit_count), 32'd8);
    chk("preflush_win", 32'(bus.win_data), 32'(9'b101100110));
    drive(1'b1, 4'b1111, 3'd4, 1'b1, 4'd2, 1'b1); tick();
    idle(); #1;
    chk("flush_count", 32'(bus.bit_count), 32'd0);
    chk("flush_win", 32'(bus.win_data), 32'd0);
    chk("flush_err", 32'(bus.err), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);

    // Empty-boundary and degenerate length cases.
    drive(1'b0, 4'd0, 3'd0, 1'b1, 4'd0, 1'b0); #1;
    chk("empty_cons0_ready", 32'(bus.cons_ready), 32'd1);
    tick();
    chk("empty_cons0_count", 32'(bus.bit_count), 32'd0);
    drive(1'b1, 4'b1111, 3'd0, 1'b0, 4'd1, 1'b0); tick();
    chk("len0_count", 32'(bus.bit_count), 32'd0);
    chk("len0_err", 32'(bus.err), 32'd0);
    drive(1'b1, 4'b1111, 3'd5, 1'b0, 4'd1, 1'b0); tick();
    idle(); #1;
    chk("len5_count", 32'(bus.bit_count), 32'd0);
    chk("len5_win", 32'(bus.win_data), 32'd0);
    chk("len5_err", 32'(bus.err), 32'(EXP_ERR));
    drive(1'b0, 4'd0, 3'd0, 1'b0, 4'd1, 1'b1); tick();
    idle(); #1;
    chk("len5_flush_err", 32'(bus.err), 32'd0);

    // Sustained load-and-consume keeps the count steady while the stream advances.
    drive(1'b1, 4'b1111, 3'd4, 1'b0, 4'd1, 1'b0); tick();
    drive(1'b1, 4'b0000, 3'd4, 1'b0, 4'd1, 1'b0); tick();
    drive(1'b1, 4'b1010, 3'd4, 1'b1, 4'd4, 1'b0); tick();
    chk("stream1_count", 32'(bus.bit_count), 32'd8);
    chk("stream1_win", 32'(bus.win_data), 32'(9'b000010100));
    drive(1'b1, 4'b1010, 3'd4, 1'b1, 4'd4, 1'b0); tick();
    idle(); #1;
    chk("stream2_count", 32'(bus.bit_count), 32'd8);
    chk("stream2_win", 32'(bus.win_data), 32'(9'b101010100));

    // Asynchronous reset mid-stream, between clock edges.
    drive(1'b1, 4'b1011, 3'd3, 1'b0, 4'd1, 1'b0); tick();
    idle(); #1;
    chk("prereset_count", 32'(bus.bit_count), 32'd11);
    #1;
    reset = 1'b0;
    #1;
    chk("async_count", 32'(bus.bit_count), 32'd0);
    chk("async_empty", 32'(bus.empty), 32'd1);
    chk("async_win", 32'(bus.win_data), 32'd0);
    reset = 1'b1;
    tick();
    chk("post_reset_count", 32'(bus.bit_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
